// File: rtl/lab2_proc_mem_squash_pkg.sv
// Shared types and helpers for the memory squash controller.
package lab2_proc_mem_squash_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } c_state_t;

  // Bits needed to hold a count in the range 0..max inclusive.
  function automatic int cnt_nbits(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/lab2_proc_mem_squash_updown.sv
// Up/down counter with load. Load has priority over increment/decrement;
// a simultaneous increment and decrement leaves the count unchanged.
module lab2_proc_mem_squash_updown
  import lab2_proc_mem_squash_pkg::*;
#(
  parameter int p_nbits = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [p_nbits-1:0] load_val,
  input  logic               inc,
  input  logic               dec,
  output logic [p_nbits-1:0] count
);

  // Count register: clear on reset, otherwise load or step.
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else
      count <= count + p_nbits'(inc) - p_nbits'(dec);
  end

endmodule

// File: rtl/lab2_proc_mem_squash_ctrl.sv
// Squash controller for in-flight memory requests. Tracks outstanding
// requests, marks older ones as wrong-path on squash, and drives the drop
// unit so each marked response is discarded exactly once. Also stalls new
// requests when the outstanding limit is reached.
// Optional build macro LAB2_PROC_MEM_SQUASH_STATS_EN adds saturating
// counters of dropped responses and squash cycles.
module lab2_proc_mem_squash_ctrl
  import lab2_proc_mem_squash_pkg::*;
#(
  parameter  int p_max_inflight = 2,
  localparam int c_cnt_nbits    = cnt_nbits(p_max_inflight)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   memreq_go,
  input  logic                   memresp_val,
  input  logic                   memresp_go,
  input  logic                   squash,
  output logic                   drop,
  output logic                   memreq_stall,
  output logic [c_cnt_nbits-1:0] inflight,
  output logic [c_cnt_nbits-1:0] drop_cnt,
  output logic                   busy
`ifdef LAB2_PROC_MEM_SQUASH_STATS_EN
  ,
  output logic [15:0]            stat_drops,
  output logic [15:0]            stat_squashes
`endif
);

  logic [c_cnt_nbits-1:0] inflight_next;
  logic [c_cnt_nbits-1:0] drop_cnt_next;
  logic                   drop_dec;
  c_state_t               state, state_next;

  // Marked responses are consumed only when actually accepted, so a
  // backpressured response keeps drop high without touching the count.
  assign drop_dec     = memresp_go && (drop_cnt != '0);
  assign drop         = memresp_val && ((drop_cnt != '0) || squash);
  assign memreq_stall = (inflight == c_cnt_nbits'(p_max_inflight));
  assign busy         = (state != IDLE);

  // Next counter values; drive both the squash reload and the FSM.
  always_comb begin
    inflight_next = inflight + c_cnt_nbits'(memreq_go) - c_cnt_nbits'(memresp_go);
    drop_cnt_next = drop_cnt;
    if (squash)
      drop_cnt_next = inflight_next;
    else if (drop_dec)
      drop_cnt_next = drop_cnt - 1'b1;
  end

  lab2_proc_mem_squash_updown #(.p_nbits(c_cnt_nbits)) u_inflight (
    .clk      (clk),
    .reset    (reset),
    .load     (1'b0),
    .load_val ('0),
    .inc      (memreq_go),
    .dec      (memresp_go),
    .count    (inflight)
  );

  // A squash re-marks everything still outstanding, so the drop count is
  // reloaded rather than accumulated; repeated squashes never double count.
  lab2_proc_mem_squash_updown #(.p_nbits(c_cnt_nbits)) u_drop_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (squash),
    .load_val (inflight_next),
    .inc      (1'b0),
    .dec      (drop_dec),
    .count    (drop_cnt)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next state follows the next counter values.
  always_comb begin
    state_next = IDLE;
    if (drop_cnt_next != '0)
      state_next = DRAIN;
    else if (inflight_next != '0)
      state_next = BUSY;
  end

`ifdef LAB2_PROC_MEM_SQUASH_STATS_EN
  // Saturating event counters for dropped responses and squash cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_drops    <= '0;
      stat_squashes <= '0;
    end else begin
      if (memresp_go && drop && (stat_drops != 16'hFFFF))
        stat_drops <= stat_drops + 16'd1;
      if (squash && (stat_squashes != 16'hFFFF))
        stat_squashes <= stat_squashes + 16'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_req_while_stall: assert property (@(posedge clk) disable iff (reset)
    !(memreq_go && memreq_stall));
  a_resp_while_empty: assert property (@(posedge clk) disable iff (reset)
    !(memresp_go && (inflight == '0)));
  a_drop_cnt_le_inflight: assert property (@(posedge clk) disable iff (reset)
    drop_cnt <= inflight);
`endif

endmodule
